ref_mem_sched: RTL and testbench

Sequencer for the 32-bank reference-pixel memory of the HEVC motion-estimation engine. Each search runs in two phases. First it preloads the search window: upstream supplies rows through a valid/ready handshake and the block fills the banks four at a time. It then sweeps the window as nine overlapping sub-areas, issuing row reads to the PE array with backpressure, and signals completion with a one-cycle `done`.

---
 rtl/ref_mem_pkg.sv | 23 ++
 rtl/ref_rd_addr_gen.sv | 65 ++++++
 rtl/ref_mem_sched.sv | 137 +++++++++++++
 tb/tb_ref_mem_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_mem_pkg.sv
// Shared types and default geometry for the reference-pixel memory sequencer.
package ref_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEF_N_BANK   = 32;
    localparam int DEF_GROUP    = 4;
    localparam int DEF_DEPTH    = 96;
    localparam int DEF_ADDR_W   = 7;
    localparam int DEF_N_SUB    = 9;
    localparam int DEF_RD_ROWS  = 64;
    localparam int DEF_SUB_STEP = 16;

    // Number of 4-bank groups filled during preload.
    localparam int DEF_N_GRP       = 8;
    localparam int DEF_PRELOAD_LEN = DEF_N_GRP * DEF_DEPTH;

endpackage

// File: rtl/ref_rd_addr_gen.sv
// Sub-area sweep counters: walks rows within each of the nine overlapping
// sub-areas and produces the read row address and sub-area index.
module ref_rd_addr_gen
    import ref_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_SUB    = DEF_N_SUB,
    parameter int RD_ROWS  = DEF_RD_ROWS,
    parameter int SUB_STEP = DEF_SUB_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_sel,
    output logic              last
);

    localparam int RROW_W = $clog2(RD_ROWS);

    logic [RROW_W-1:0] rrow_q, rrow_d;
    logic [3:0]        sub_q, sub_d;
    logic [1:0]        col_q, col_d;
    logic              row_last;

    assign row_last = (rrow_q == RROW_W'(RD_ROWS - 1));

    always_comb begin
        rrow_d = rrow_q;
        sub_d  = sub_q;
        col_d  = col_q;
        if (clear) begin
            rrow_d = '0;
            sub_d  = '0;
            col_d  = '0;
        end else if (step) begin
            if (row_last) begin
                rrow_d = '0;
                sub_d  = sub_q + 4'd1;
                col_d  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            end else begin
                rrow_d = rrow_q + RROW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrow_q <= '0;
            sub_q  <= '0;
            col_q  <= '0;
        end else begin
            rrow_q <= rrow_d;
            sub_q  <= sub_d;
            col_q  <= col_d;
        end
    end

    // Columns of the 3x3 sub-area grid are offset by SUB_STEP rows.
    assign rd_addr = ADDR_W'(col_q) * ADDR_W'(SUB_STEP) + ADDR_W'(rrow_q);
    assign rd_sel  = sub_q;
    assign last    = row_last && (sub_q == 4'(N_SUB - 1));

endmodule

// File: rtl/ref_mem_sched.sv
// Two-phase search sequencer: preloads the 32 banks four at a time, then
// sweeps nine sub-areas issuing row reads to the PE array.
module ref_mem_sched
    import ref_mem_pkg::*;
#(
    parameter int N_BANK   = DEF_N_BANK,
    parameter int GROUP    = DEF_GROUP,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_SUB    = DEF_N_SUB,
    parameter int RD_ROWS  = DEF_RD_ROWS,
    parameter int SUB_STEP = DEF_SUB_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [N_BANK-1:0] bank_we,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              pe_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_sel,
    output logic              busy,
    output logic              done
);

    localparam logic [N_BANK-1:0] GRP_MASK = N_BANK'({GROUP{1'b1}});

    state_e            state_q, state_d;
    logic [2:0]        grp_q, grp_d;
    logic [ADDR_W-1:0] row_q, row_d;

    logic              fire;
    logic              last_fire;
    logic              read_beat;
    logic              gen_clear;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [3:0]        gen_sel;

    // Handshakes are combinational: a write fires on wr_valid while in LOAD,
    // a read beat issues on pe_ready while in READ, both in the same cycle.
    assign fire      = (state_q == ST_LOAD) && wr_valid;
    assign last_fire = fire && (grp_q == 3'(DEF_N_GRP - 1)) && (row_q == ADDR_W'(DEPTH - 1));
    assign read_beat = (state_q == ST_READ) && pe_ready;
    assign gen_clear = (state_q == ST_IDLE);

    ref_rd_addr_gen #(
        .ADDR_W   (ADDR_W),
        .N_SUB    (N_SUB),
        .RD_ROWS  (RD_ROWS),
        .SUB_STEP (SUB_STEP)
    ) u_rd_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (gen_clear),
        .step    (read_beat),
        .rd_addr (gen_addr),
        .rd_sel  (gen_sel),
        .last    (gen_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: if (last_fire) state_d = ST_READ;
            ST_READ: if (read_beat && gen_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        grp_d = grp_q;
        row_d = row_q;
        if (state_q == ST_IDLE) begin
            grp_d = '0;
            row_d = '0;
        end else if (fire) begin
            if (row_q == ADDR_W'(DEPTH - 1)) begin
                row_d = '0;
                grp_d = grp_q + 3'd1;
            end else begin
                row_d = row_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q <= '0;
            row_q <= '0;
        end else begin
            grp_q <= grp_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        wr_ready = 1'b0;
        bank_we  = '0;
        wr_addr  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        rd_sel   = '0;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        if (state_q == ST_LOAD) begin
            wr_ready = 1'b1;
            wr_addr  = row_q;
            if (fire) begin
                bank_we = GRP_MASK << (GROUP * int'(grp_q));
            end
        end
        if (state_q == ST_READ) begin
            rd_en   = read_beat;
            rd_addr = gen_addr;
            rd_sel  = gen_sel;
        end
    end

endmodule

// File: tb/tb_ref_mem_sched.sv
// Scoreboard bench for ref_mem_sched: full searches, gapped handshakes,
// abort, ignored start and asynchronous reset mid-sweep.
module tb_ref_mem_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] bank_we;
    logic [6:0]  wr_addr;
    logic        pe_ready;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [3:0]  rd_sel;
    logic        busy;
    logic        done;

    ref_mem_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .bank_we  (bank_we),
        .wr_addr  (wr_addr),
        .pe_ready (pe_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_sel   (rd_sel),
        .busy     (busy),
        .done     (done)
    );

    logic [38:0] wexp_q[$];
    logic [10:0] rexp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int widx = 0;
    int ridx = 0;
    int dones = 0;
    int start_edge = 0;
    bit gap_mode = 0;
    bit nogap = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input driver for the handshake inputs: held high, or 50% random gaps.
    initial begin
        wr_valid = 0;
        pe_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gap_mode) begin
                wr_valid = 1'($urandom_range(0, 1));
                pe_ready = 1'($urandom_range(0, 1));
            end else begin
                wr_valid = 1;
                pe_ready = 1;
            end
        end
    end

    // Monitor: pops the expected queues whenever the DUT issues a write or beat.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            widx = 0;
            ridx = 0;
        end else begin
            if (start && !busy) begin
                widx = 0;
                ridx = 0;
                start_edge = cyc + 1;
            end
            if (wr_valid && wr_ready) begin
                if (wexp_q.size() == 0) begin
                    check_v("wr_unexpected", 64'(widx), 64'hFFFF);
                end else begin
                    check_v("wr_beat", {bank_we, wr_addr}, wexp_q.pop_front());
                end
                if (widx == 0)   check_v("wr_fire0",   {bank_we, wr_addr}, {32'h0000000F, 7'd0});
                if (widx == 96)  check_v("wr_fire96",  {bank_we, wr_addr}, {32'h000000F0, 7'd0});
                if (widx == 767) check_v("wr_fire767", {bank_we, wr_addr}, {32'hF0000000, 7'd95});
                widx++;
            end else begin
                check_v("wr_we_idle", bank_we, 0);
            end
            if (!pe_ready) check_v("rd_en_no_ready", rd_en, 0);
            if (rd_en) begin
                if (rexp_q.size() == 0) begin
                    check_v("rd_unexpected", 64'(ridx), 64'hFFFF);
                end else begin
                    check_v("rd_beat", {rd_sel, rd_addr}, rexp_q.pop_front());
                end
                if (ridx == 64)  check_v("rd_beat64",  {rd_sel, rd_addr}, {4'd1, 7'd16});
                if (ridx == 128) check_v("rd_beat128", {rd_sel, rd_addr}, {4'd2, 7'd32});
                if (ridx == 192) check_v("rd_beat192", {rd_sel, rd_addr}, {4'd3, 7'd0});
                if (ridx == 575) check_v("rd_beat575", {rd_sel, rd_addr}, {4'd8, 7'd95});
                ridx++;
            end
            if (done) begin
                dones++;
                // Cycle k spans edges k-1..k; done must fall in cycle start+1345.
                if (nogap) check_v("done_latency", 64'(cyc + 1 - start_edge), 64'd1345);
            end
        end
    end

    task automatic push_search();
        wexp_q.delete();
        rexp_q.delete();
        for (int i = 0; i < 768; i++) begin
            logic [31:0] m;
            m = 32'h0000000F << (4 * (i / 96));
            wexp_q.push_back({m, 7'(i % 96)});
        end
        for (int b = 0; b < 576; b++) begin
            int s;
            int c;
            s = b / 64;
            c = s % 3;
            rexp_q.push_back({4'(s), 7'(c * 16 + b % 64)});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_w(input int n);
        for (int k = 0; k < 4000 && widx < n; k++) begin
            @(posedge clk);
            #1;
        end
        check_v("wait_writes", 64'(widx >= n), 1);
    endtask

    task automatic wait_r(input int n);
        for (int k = 0; k < 6000 && ridx < n; k++) begin
            @(posedge clk);
            #1;
        end
        check_v("wait_beats", 64'(ridx >= n), 1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = dones;
        for (int k = 0; k < budget && dones == d0; k++) begin
            @(posedge clk);
            #1;
        end
        check_v("done_seen", 64'(dones - d0), 1);
        check_v("write_count", 64'(widx), 768);
        check_v("beat_count", 64'(ridx), 576);
        check_v("wexp_empty", 64'(wexp_q.size()), 0);
        check_v("rexp_empty", 64'(rexp_q.size()), 0);
        @(negedge clk);
        check_v("busy_after", busy, 0);
        check_v("done_one_cycle", done, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_v({tag, "_wr_ready"}, wr_ready, 0);
        check_v({tag, "_bank_we"}, bank_we, 0);
        check_v({tag, "_wr_addr"}, wr_addr, 0);
        check_v({tag, "_rd_en"}, rd_en, 0);
        check_v({tag, "_rd_addr"}, rd_addr, 0);
        check_v({tag, "_rd_sel"}, rd_sel, 0);
        check_v({tag, "_busy"}, busy, 0);
        check_v({tag, "_done"}, done, 0);
    endtask

    initial begin
        int d0;
        rst_n = 0;
        start = 0;
        abort = 0;

        // Reset state with handshake inputs already high.
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        #1 rst_n = 1;

        // Full search, no gaps.
        nogap = 1;
        push_search();
        pulse_start();
        wait_done(3000);

        // Gapped search with a start pulse during READ that must be ignored.
        gap_mode = 1;
        nogap = 0;
        push_search();
        pulse_start();
        wait_r(100);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_done(8000);
        gap_mode = 0;
        repeat (2) @(posedge clk);

        // Abort in the cycle of preload fire #300.
        push_search();
        pulse_start();
        wait_w(300);
        check_v("abort_at_fire", 64'(widx), 300);
        d0 = dones;
        abort = 1;
        @(posedge clk);
        #1 abort = 0;
        check_v("abort_fires", 64'(widx), 301);
        check_v("abort_wexp_left", 64'(wexp_q.size()), 467);
        check_v("abort_busy", busy, 0);
        check_v("abort_wr_ready", wr_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check_v("abort_no_done", 64'(dones - d0), 0);

        // New start after abort restarts preload from group 0, row 0.
        nogap = 1;
        push_search();
        pulse_start();
        wait_done(3000);

        // Asynchronous reset in the middle of READ.
        push_search();
        pulse_start();
        wait_r(50);
        d0 = dones;
        rst_n = 0;
        #1;
        check_outputs_zero("midreset");
        wexp_q.delete();
        rexp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check_v("post_reset_busy", busy, 0);
        check_v("post_reset_no_done", 64'(dones - d0), 0);
        push_search();
        pulse_start();
        wait_done(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
